// File: rtl/mcpu_run_ctrl.sv
// rtl/mcpu_run_ctrl.sv - sequences one MCPU program run: image load, CPU release, halt/timeout watch
//
// Purpose:
//   Streams a program image into the MCPU RAM over a valid/ready port while the
//   CPU is held in reset, releases the CPU on start, and ends the run when the
//   CPU PC reaches halt_pc or when the RUN-cycle budget (MAX_CYCLES) expires.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   clear             synchronous abort/re-arm pulse, returns to IDLE
//   load_valid/ready  image word handshake; load_data word, load_last final word
//   start             level-sampled run request (IDLE, READY, DONE)
//   halt_pc           PC value marking program end
//   ram_we/addr/wdata registered RAM write port, one cycle after each handshake
//   cpu_hold          active-high reset to the MCPU
//   cpu_pc            MCPU PC tap, compared only in RUN
//   busy              state is LOAD or RUN
//   done/timeout      sticky run result flags, cleared by clear or start
//   load_ovf          image filled the whole RAM without load_last
//   word_count        words written by the last load
//   cycle_count       RUN cycles of the current/last run (saturating)

module mcpu_run_ctrl #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int CNT_WIDTH   = 32,
  parameter int MAX_CYCLES  = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  halt_pc,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [INSTR_WIDTH-1:0] ram_wdata,
  output logic                   cpu_hold,
  input  logic [ADDR_WIDTH-1:0]  cpu_pc,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   load_ovf,
  output logic [ADDR_WIDTH:0]    word_count,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [CNT_WIDTH-1:0]  BUDGET_END = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_SAT    = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  logic   xfer;

  // Ready is decoded from state so a word offered in IDLE is taken at once.
  assign load_ready = (state == IDLE) || (state == LOAD);
  assign busy       = (state == LOAD) || (state == RUN);
  assign xfer       = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cpu_hold    <= 1'b1;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      load_ovf    <= 1'b0;
      word_count  <= '0;
      cycle_count <= '0;
    end else begin
      // Write strobe is a single-cycle pulse per accepted word.
      ram_we <= 1'b0;

      if (clear) begin
        // word_count and cycle_count stay visible after an abort.
        state    <= IDLE;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        timeout  <= 1'b0;
        load_ovf <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (xfer) begin
              ram_we     <= 1'b1;
              ram_addr   <= '0;
              ram_wdata  <= load_data;
              word_count <= (ADDR_WIDTH+1)'(1);
              state      <= load_last ? READY : LOAD;
            end else if (start) begin
              // Run whatever the RAM already holds.
              state       <= RUN;
              cpu_hold    <= 1'b0;
              cycle_count <= '0;
              done        <= 1'b0;
              timeout     <= 1'b0;
            end
          end

          LOAD: begin
            if (xfer) begin
              ram_we     <= 1'b1;
              ram_addr   <= word_count[ADDR_WIDTH-1:0];
              ram_wdata  <= load_data;
              word_count <= word_count + 1'b1;
              if (load_last) begin
                state <= READY;
              end else if (word_count[ADDR_WIDTH-1:0] == LAST_ADDR) begin
                // RAM is full: keep the word, flag the missing load_last.
                load_ovf <= 1'b1;
                state    <= READY;
              end
            end
          end

          READY: begin
            if (start) begin
              state       <= RUN;
              cpu_hold    <= 1'b0;
              cycle_count <= '0;
              done        <= 1'b0;
              timeout     <= 1'b0;
            end
          end

          RUN: begin
            // The cycle that sees the halt PC still counts as a RUN cycle.
            if (cycle_count != CNT_SAT) begin
              cycle_count <= cycle_count + 1'b1;
            end
            // Halt match is tested first so it wins over budget expiry.
            if (cpu_pc == halt_pc) begin
              done     <= 1'b1;
              cpu_hold <= 1'b1;
              state    <= DONE;
            end else if (cycle_count == BUDGET_END) begin
              timeout  <= 1'b1;
              cpu_hold <= 1'b1;
              state    <= DONE;
            end
          end

          DONE: begin
            // CPU stays held; its register file keeps the final values.
            if (start) begin
              state       <= RUN;
              cpu_hold    <= 1'b0;
              cycle_count <= '0;
              done        <= 1'b0;
              timeout     <= 1'b0;
            end
          end

          default: begin
            state    <= IDLE;
            cpu_hold <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcpu_run_ctrl.sv
// tb/tb_mcpu_run_ctrl.sv - self-checking bench for mcpu_run_ctrl
module tb_mcpu_run_ctrl;

  localparam int IW = 16;
  localparam int AW = 8;
  localparam int CW = 32;
  localparam int MC = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [IW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] halt_pc = '0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [IW-1:0] ram_wdata;
  logic          cpu_hold;
  logic [AW-1:0] cpu_pc;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          load_ovf;
  logic [AW:0]   word_count;
  logic [CW-1:0] cycle_count;

  mcpu_run_ctrl #(
    .INSTR_WIDTH(IW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW),
    .MAX_CYCLES (MC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .start      (start),
    .halt_pc    (halt_pc),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cpu_hold   (cpu_hold),
    .cpu_pc     (cpu_pc),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .load_ovf   (load_ovf),
    .word_count (word_count),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // PC stub: held at 0 while cpu_hold, +1 per released cycle, or stuck at 0xEE.
  logic [AW-1:0] pc_cnt = '0;
  logic          pc_stuck = 1'b0;
  always @(posedge clk) pc_cnt <= cpu_hold ? '0 : pc_cnt + 1'b1;
  assign cpu_pc = pc_stuck ? 8'hEE : pc_cnt;

  // RAM model fed by the write port.
  logic [IW-1:0] mem [256];
  int            wr_count = 0;
  logic [AW-1:0] last_wr = '0;
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_count      <= wr_count + 1;
      last_wr       <= ram_addr;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int clr; int val; int data; int last; int st;
    int we; int addr; int wdata; int rdy; int bsy; int hold; int dn; int wc; int cc;
  } vec_t;

  vec_t tbl [16];

  task automatic clear_pulse();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  task automatic load_words(input int n, input logic [IW-1:0] base, input bit with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = base + IW'(i);
      load_last  = with_last && (i == n - 1);
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Pulse start and count the RUN cycles (busy high) until the run ends.
  task automatic run_and_count(output int n);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("run_ended", busy, 0);
  endtask

  initial begin
    int n;
    int w0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cpu_hold", cpu_hold, 1);
    chk("rst.ram_we", ram_we, 0);
    chk("rst.ram_addr", ram_addr, 0);
    chk("rst.ram_wdata", ram_wdata, 0);
    chk("rst.done", done, 0);
    chk("rst.timeout", timeout, 0);
    chk("rst.load_ovf", load_ovf, 0);
    chk("rst.word_count", word_count, 0);
    chk("rst.cycle_count", cycle_count, 0);
    chk("rst.load_ready", load_ready, 1);
    chk("rst.busy", busy, 0);
    @(negedge clk) reset = 1'b1;

    // ---- table: 3-word load, short run, DONE/clear/start corners ----
    //            clr val data     last st   we addr wdata    rdy bsy hold dn wc cc
    tbl[0]  = '{0, 1, 'h1008, 0, 0,  1, 0, 'h1008,  1, 1, 1, 0, 1, 0};
    tbl[1]  = '{0, 1, 'h1101, 0, 0,  1, 1, 'h1101,  1, 1, 1, 0, 2, 0};
    tbl[2]  = '{0, 1, 'hF80A, 1, 0,  1, 2, 'hF80A,  0, 0, 1, 0, 3, 0};
    tbl[3]  = '{0, 1, 'hDEAD, 0, 0,  0, 0, 0,       0, 0, 1, 0, 3, 0};
    tbl[4]  = '{0, 0, 0,      0, 1,  0, 0, 0,       0, 1, 0, 0, 3, 0};
    tbl[5]  = '{0, 0, 0,      0, 0,  0, 0, 0,       0, 1, 0, 0, 3, 1};
    tbl[6]  = '{0, 0, 0,      0, 0,  0, 0, 0,       0, 1, 0, 0, 3, 2};
    tbl[7]  = '{0, 0, 0,      0, 0,  0, 0, 0,       0, 0, 1, 1, 3, 3};
    tbl[8]  = '{0, 1, 'h1234, 1, 0,  0, 0, 0,       0, 0, 1, 1, 3, 3};
    tbl[9]  = '{1, 0, 0,      0, 1,  0, 0, 0,       1, 0, 1, 0, 3, 3};
    tbl[10] = '{0, 0, 0,      0, 1,  0, 0, 0,       0, 1, 0, 0, 3, 0};
    tbl[11] = '{0, 0, 0,      0, 0,  0, 0, 0,       0, 1, 0, 0, 3, 1};
    tbl[12] = '{0, 0, 0,      0, 0,  0, 0, 0,       0, 1, 0, 0, 3, 2};
    tbl[13] = '{0, 0, 0,      0, 0,  0, 0, 0,       0, 0, 1, 1, 3, 3};
    tbl[14] = '{1, 1, 'h5555, 0, 0,  0, 0, 0,       1, 0, 1, 0, 3, 3};
    tbl[15] = '{0, 1, 'hABCD, 1, 0,  1, 0, 'hABCD,  0, 0, 1, 0, 1, 3};
    halt_pc  = 8'd2;
    pc_stuck = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      clear      = tbl[i].clr[0];
      load_valid = tbl[i].val[0];
      load_data  = IW'(tbl[i].data);
      load_last  = tbl[i].last[0];
      start      = tbl[i].st[0];
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.ram_we", i), ram_we, tbl[i].we);
      if (tbl[i].we != 0) begin
        chk($sformatf("v%0d.ram_addr", i), ram_addr, tbl[i].addr);
        chk($sformatf("v%0d.ram_wdata", i), ram_wdata, tbl[i].wdata);
      end
      chk($sformatf("v%0d.load_ready", i), load_ready, tbl[i].rdy);
      chk($sformatf("v%0d.busy", i), busy, tbl[i].bsy);
      chk($sformatf("v%0d.cpu_hold", i), cpu_hold, tbl[i].hold);
      chk($sformatf("v%0d.done", i), done, tbl[i].dn);
      chk($sformatf("v%0d.timeout", i), timeout, 0);
      chk($sformatf("v%0d.word_count", i), word_count, tbl[i].wc);
      chk($sformatf("v%0d.cycle_count", i), cycle_count, tbl[i].cc);
    end
    @(negedge clk);
    clear = 1'b0; load_valid = 1'b0; load_last = 1'b0; start = 1'b0;

    // ---- 24-word image, halt at PC 8 ----
    clear_pulse();
    w0 = wr_count;
    load_words(24, 16'h2000, 1'b1);
    @(posedge clk);
    #1;
    chk("img.writes", wr_count - w0, 24);
    chk("img.last_addr", last_wr, 23);
    for (int i = 0; i < 24; i++) chk($sformatf("img.mem%0d", i), mem[i], 16'h2000 + i);
    chk("img.word_count", word_count, 24);
    chk("img.load_ready", load_ready, 0);
    halt_pc = 8'd8;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    chk("img.hold_falls", cpu_hold, 0);
    @(negedge clk) start = 1'b0;
    n = 0;
    while (n < 500) begin
      if (!cpu_hold) n++;
      if (cpu_pc == halt_pc) break;
      @(negedge clk);
    end
    chk("img.pc_reached", cpu_pc, 8);
    @(posedge clk);
    #1;
    chk("img.done", done, 1);
    chk("img.timeout", timeout, 0);
    chk("img.cycle_count", cycle_count, n);
    chk("img.cpu_hold", cpu_hold, 1);

    // ---- timeout: PC never reaches halt_pc ----
    clear_pulse();
    pc_stuck = 1'b1;
    run_and_count(n);
    chk("to.run_cycles", n, MC);
    chk("to.timeout", timeout, 1);
    chk("to.done", done, 0);
    chk("to.cpu_hold", cpu_hold, 1);
    chk("to.cycle_count", cycle_count, MC);

    // ---- halt on the last budget cycle, restarted from DONE ----
    pc_stuck = 1'b0;
    halt_pc  = 8'(MC - 1);
    run_and_count(n);
    chk("edge.run_cycles", n, MC);
    chk("edge.done", done, 1);
    chk("edge.timeout", timeout, 0);
    chk("edge.cycle_count", cycle_count, MC);

    // ---- overflow: 256 words without load_last ----
    clear_pulse();
    w0 = wr_count;
    load_words(256, 16'h5A00, 1'b0);
    @(posedge clk);
    #1;
    chk("ovf.writes", wr_count - w0, 256);
    chk("ovf.last_addr", last_wr, 8'hFF);
    chk("ovf.mem255", mem[255], 16'h5AFF);
    chk("ovf.mem0", mem[0], 16'h5A00);
    chk("ovf.load_ovf", load_ovf, 1);
    chk("ovf.word_count", word_count, 256);
    chk("ovf.load_ready", load_ready, 0);
    chk("ovf.busy", busy, 0);
    clear_pulse();
    #1;
    chk("ovf.cleared", load_ovf, 0);
    chk("ovf.wc_held", word_count, 256);

    // ---- clear after 5 words of LOAD (word offered on the clear cycle) ----
    w0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = 16'h7700 + IW'(i);
    end
    @(negedge clk);
    load_data = 16'h7705;
    clear     = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    load_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort.writes", wr_count - w0, 5);
    chk("abort.ram_we", ram_we, 0);
    chk("abort.load_ready", load_ready, 1);
    chk("abort.busy", busy, 0);
    chk("abort.word_count", word_count, 5);

    // ---- reset while a RAM write is pending ----
    w0 = wr_count;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'h7800;
    @(posedge clk);
    #1;
    chk("rstw.ram_we_before", ram_we, 1);
    reset = 1'b0;
    #1;
    chk("rstw.ram_we_after", ram_we, 0);
    chk("rstw.word_count", word_count, 0);
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstw.no_write", wr_count - w0, 0);
    @(negedge clk) reset = 1'b1;

    // ---- reset pulse during RUN, then run existing RAM ----
    pc_stuck = 1'b1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    chk("rrun.busy", busy, 1);
    chk("rrun.cpu_hold", cpu_hold, 0);
    @(negedge clk) start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rrun.hold_async", cpu_hold, 1);
    chk("rrun.busy_after", busy, 0);
    chk("rrun.load_ready", load_ready, 1);
    chk("rrun.cycle_count", cycle_count, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    chk("rerun.busy", busy, 1);
    chk("rerun.cpu_hold", cpu_hold, 0);
    @(negedge clk) start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcpu_run_ctrl.md
Name: mcpu_run_ctrl

Overview:
- Sequences one MCPU program run.
- Streams a program image into the MCPU RAM over a valid/ready port, holds the CPU in reset during load, releases it on start, and watches the CPU PC.
- Ends the run when the PC reaches a programmed halt address, or when a cycle budget expires.
- Sits between the bench or host loader and the MCPU instance (RAM write port, CPU reset, PC tap).

Parameters:
INSTR_WIDTH, 16, RAM word width ({opcode, operand, operand/imm8}).
ADDR_WIDTH, 8, RAM/PC address width; image holds at most 2^ADDR_WIDTH words.
CNT_WIDTH, 32, width of cycle_count.
MAX_CYCLES, 100000, RUN-cycle budget before timeout; must be below 2^CNT_WIDTH.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
clear  in  1  synchronous abort/re-arm pulse; returns the block to IDLE from any state.
load_valid  in  1  image word valid.
load_ready  out  1  block accepts an image word.
load_data  in  INSTR_WIDTH  image word.
load_last  in  1  marks the final word of the image.
start  in  1  begin run, level-sampled.
halt_pc  in  ADDR_WIDTH  PC value that marks program end (e.g. 8 for the hailstone program).
ram_we  out  1  RAM write strobe.
ram_addr  out  ADDR_WIDTH  RAM write address.
ram_wdata  out  INSTR_WIDTH  RAM write data.
cpu_hold  out  1  active-high reset to the MCPU.
cpu_pc  in  ADDR_WIDTH  current MCPU PC.
busy  out  1  state is LOAD or RUN.
done  out  1  run ended at halt_pc (sticky until clear or start).
timeout  out  1  run exceeded MAX_CYCLES (sticky until clear or start).
load_ovf  out  1  image reached the last address without load_last (sticky until clear).
word_count  out  ADDR_WIDTH+1  words written in the last load.
cycle_count  out  CNT_WIDTH  RUN cycles of the current/last run.

Behaviour:
Reset (reset=0, async):
- State IDLE.
- cpu_hold=1; ram_we=0; ram_addr=0; ram_wdata=0.
- done=timeout=load_ovf=0; word_count=0; cycle_count=0.
- load_ready=1 (combinational: state IDLE or LOAD).

Handshake:
- A word transfers on a rising edge with load_valid&&load_ready.
- load_data/load_last must stay stable while load_valid=1 and load_ready=0.

States:
- IDLE:
  - Handshake: write word to address 0, word_count=1, go LOAD; if load_last, go READY instead.
  - start=1 with no handshake: run the existing RAM contents (go RUN).
- LOAD:
  - Each handshake writes to address word_count and increments word_count.
  - load_last handshake -> READY.
  - Handshake at address 2^ADDR_WIDTH-1 without load_last: word is written, load_ovf=1, -> READY.
  - start is ignored.
- READY:
  - start=1 -> RUN.
  - load_ready=0.
- RUN:
  - cpu_hold=0 from the first RUN cycle.
  - cycle_count cleared on RUN entry, then +1 per RUN cycle, saturating.
  - cpu_pc==halt_pc sampled -> done=1, -> DONE.
  - Otherwise cycle_count==MAX_CYCLES-1 -> timeout=1, -> DONE.
  - Halt match and budget end in the same cycle: done wins, timeout stays 0.
- DONE:
  - cpu_hold=1 from the next edge; the CPU register state is retained for inspection (the MCPU register file is not reset by hold).
  - start=1 -> RUN again: done/timeout cleared, cycle_count restarts.
  - A handshake is not accepted.

RAM write timing:
- ram_we, ram_addr and ram_wdata are registered: asserted exactly one cycle after the handshake edge, one word per cycle.
- Back-to-back handshakes produce back-to-back writes at consecutive addresses.

clear:
- Highest priority. Next state IDLE, cpu_hold=1, ram_we=0.
- done/timeout/load_ovf cleared; word_count and cycle_count are held.
- clear during LOAD abandons the image; words already written remain in RAM.

Other rules:
- start and clear together: clear wins.
- reset asserted mid-load or mid-run: immediate IDLE and hold; no RAM write is completed after assertion.
- cpu_pc is compared only in RUN; hold cycles never count.

Test Plan:
- Load 3 words 0x1008, 0x1101, 0xF80A back-to-back with load_last on the third -> ram_we high for 3 consecutive cycles at addresses 0, 1, 2 one cycle after each handshake; word_count=3; state READY; load_ready=0.
- Load the 24-word hailstone image (addresses 0-23, zero gaps), halt_pc=8, start -> cpu_hold falls the next cycle; done=1, timeout=0; MCPU R15==1; cycle_count equals the bench-counted cycles until PC first reads 8.
- PC stub never reaching halt_pc, MAX_CYCLES=50 -> timeout=1 after exactly 50 RUN cycles; cycle_count=50; cpu_hold=1; done=0.
- Halt match on cycle MAX_CYCLES-1 -> done=1, timeout=0.
- 256 words without load_last (ADDR_WIDTH=8) -> last write at 0xFF; load_ovf=1; word_count=256; READY.
- clear after 5 words of LOAD, then reset pulse during RUN -> IDLE with load_ready=1; no further ram_we; cpu_hold=1 asynchronously on reset; start afterwards runs from the existing RAM.
